// File: rtl/smart_led_pkg.sv
// Shared types and defaults for the smart-LED bit decoder.
// Provides the FSM state enum, pixel width, default timing parameters
// and a helper that classifies which states count as "frame in progress".
package smart_led_pkg;

   localparam int PIXEL_W = 24;

   localparam int DEF_THRESHOLD    = 40;
   localparam int DEF_RESET_CYCLES = 2500;
   localparam int DEF_MAX_HIGH     = 255;
   localparam int DEF_CNT_W        = 12;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_FORWARD
   } state_t;

   // SYNC and IDLE are the only states outside a frame.
   function automatic logic is_busy(input state_t s);
      return (s == ST_HIGH) || (s == ST_LOW) || (s == ST_FORWARD);
   endfunction

endpackage

// File: rtl/smart_led_bit_decoder_if.sv
// Bus bundle between the input selector / PWM stage and the decoder.
// Signals: din (serial in), rgb_out/rgb_valid (latched pixel + pulse),
// dout (forwarded stream), busy (frame in progress), err (error pulse).
// slave = decoder side, master = the environment driving din.
interface smart_led_bit_decoder_if;
   import smart_led_pkg::*;

   logic               din;
   logic [PIXEL_W-1:0] rgb_out;
   logic               rgb_valid;
   logic               dout;
   logic               busy;
   logic               err;

   modport master (
      output din,
      input  rgb_out, rgb_valid, dout, busy, err
   );

   modport slave (
      input  din,
      output rgb_out, rgb_valid, dout, busy, err
   );

endinterface

// File: rtl/smart_led_pulse_timer.sv
// Pulse timer: registers din, detects rise/fall, and counts cycles since the last edge.
// Latency: rise/fall are combinational from din_i vs din_q; count is registered.
// Backpressure: none, free-running on every clk.
// Ports: clk, rst (async active-high), din_i; rise_o, fall_o, din_q_o, cnt_o.
module smart_led_pulse_timer
   import smart_led_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_i,
   output logic             rise_o,
   output logic             fall_o,
   output logic             din_q_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic             din_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign rise_o  = din_i & ~din_q;
   assign fall_o  = ~din_i & din_q;
   assign din_q_o = din_q;
   assign cnt_o   = cnt_q;

   // Loading 1 on an edge means that, on the cycle a fall is seen, the
   // count equals the number of cycles din was sampled high.
   always_comb begin
      cnt_d = cnt_q;
      if (rise_o || fall_o) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         din_q <= din_i;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/smart_led_bit_decoder.sv
// Smart-LED bit decoder: pulse-width decode of 24 bits into a pixel, forwards later bits.
// Latency: bit shifted on the cycle the fall is seen; rgb_valid 1 cycle after last gap sample.
// Backpressure: none; rgb_valid is a single-cycle pulse the consumer must take.
// Ports: clk, rst (async active-high), led_if (slave): din in; rgb_out, rgb_valid,
// dout, busy, err out. All outputs registered.
// Build option: SMART_LED_FORWARD_EN enables dout forwarding; otherwise dout is 0.
module smart_led_bit_decoder
   import smart_led_pkg::*;
#(
   parameter int THRESHOLD    = DEF_THRESHOLD,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int MAX_HIGH     = DEF_MAX_HIGH,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   smart_led_bit_decoder_if.slave  led_if
);

   localparam int BIT_W = $clog2(PIXEL_W + 1);

   // Compare against terminal-1 so the event fires on the edge that samples
   // the terminal cycle itself, letting a coincident rise take priority.
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] HIGH_TC = CNT_W'(MAX_HIGH - 1);
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

   logic             rise;
   logic             fall;
   logic             din_q;
   logic [CNT_W-1:0] cnt;

   smart_led_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .din_i   (led_if.din),
      .rise_o  (rise),
      .fall_o  (fall),
      .din_q_o (din_q),
      .cnt_o   (cnt)
   );

   state_t             state_q, state_d;
   logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
   logic [PIXEL_W-1:0] shreg_q, shreg_d;
   logic [PIXEL_W-1:0] rgb_q, rgb_d;
   logic               rgb_vld_q, rgb_vld_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic gap_done;
   logic stuck;
   logic bit_val;

   // Current cycle is the RESET_CYCLES-th consecutive low sample.
   assign gap_done = ~din_q & ~rise & (cnt == GAP_TC);
   // Current cycle is the MAX_HIGH-th consecutive high sample.
   assign stuck    = din_q & ~fall & (cnt == HIGH_TC);
   assign bit_val  = (cnt >= THR);

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      rgb_d     = rgb_q;
      rgb_vld_d = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_SYNC: begin
            if (gap_done) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (rise) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            if (fall) begin
               shreg_d  = {shreg_q[PIXEL_W-2:0], bit_val};
               bitcnt_d = bitcnt_q + BIT_W'(1);
               state_d  = (bitcnt_q == BIT_W'(PIXEL_W - 1)) ? ST_FORWARD : ST_LOW;
            end else if (stuck) begin
               err_d    = 1'b1;
               bitcnt_d = '0;
               state_d  = ST_SYNC;
            end
         end
         ST_LOW: begin
            if (rise) begin
               state_d = ST_HIGH;
            end else if (gap_done) begin
               // Gap arrived before 24 bits: drop the partial pixel.
               if (bitcnt_q != '0) err_d = 1'b1;
               shreg_d  = '0;
               bitcnt_d = '0;
               state_d  = ST_IDLE;
            end
         end
         ST_FORWARD: begin
            if (gap_done) begin
               rgb_d     = shreg_q;
               rgb_vld_d = 1'b1;
               bitcnt_d  = '0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase

      busy_d = is_busy(state_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_SYNC;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         rgb_q     <= '0;
         rgb_vld_q <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         rgb_q     <= rgb_d;
         rgb_vld_q <= rgb_vld_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

`ifdef SMART_LED_FORWARD_EN
   logic dout_q, dout_d;

   // Registering din while FORWARD is the next state makes dout equal din_q
   // for every cycle spent in FORWARD, i.e. din delayed by one cycle.
   always_comb begin
      dout_d = (state_d == ST_FORWARD) & led_if.din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dout_q <= 1'b0;
      else     dout_q <= dout_d;
   end

   assign led_if.dout = dout_q;
`else
   assign led_if.dout = 1'b0;
`endif

   assign led_if.rgb_out   = rgb_q;
   assign led_if.rgb_valid = rgb_vld_q;
   assign led_if.err       = err_q;
   assign led_if.busy      = busy_q;

endmodule

// File: tb/tb_smart_led_bit_decoder.sv
// Self-checking bench for smart_led_bit_decoder (THRESHOLD=40, RESET_CYCLES=300).
// Frames are described as a list of high widths; expectations come from the
// pulse-width rules applied to that list.
module tb_smart_led_bit_decoder;

   localparam int THR  = 40;
   localparam int RC   = 300;
   localparam int PER  = 100;

`ifdef SMART_LED_FORWARD_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   smart_led_bit_decoder_if led_if();

   smart_led_bit_decoder #(
      .THRESHOLD    (THR),
      .RESET_CYCLES (RC),
      .MAX_HIGH     (255),
      .CNT_W        (12)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .led_if (led_if)
   );

   int checks = 0;
   int errors = 0;

   // Monitor state, cleared per scenario.
   int          stepn, n_valid, n_err, first_evt, dout_mis, dout_hi, tail_start;
   logic [23:0] last_rgb;
   logic        window;
   int          hq[$];
   logic [23:0] model_rgb;

   typedef struct {
      logic [47:0] data;
      int          nbits;
      int          h1;
      int          h0;
      logic [23:0] exp_rgb;
      int          exp_valid;
      int          exp_err;
      int          exp_dhi;
   } vec_t;

   vec_t vt[5];

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      stepn = 0; n_valid = 0; n_err = 0; first_evt = 0;
      dout_mis = 0; dout_hi = 0; tail_start = 0; last_rgb = '0;
   endtask

   task automatic sample();
      stepn++;
      if (led_if.rgb_valid) begin
         n_valid++;
         last_rgb = led_if.rgb_out;
         if (first_evt == 0) first_evt = stepn;
      end
      if (led_if.err) begin
         n_err++;
         if (first_evt == 0) first_evt = stepn;
      end
      if (led_if.dout !== (window & led_if.din & (FWD == 1))) dout_mis++;
      if (led_if.dout) dout_hi++;
   endtask

   task automatic drive(input logic v, input int n);
      for (int k = 0; k < n; k++) begin
         led_if.din = v;
         @(posedge clk);
         #1;
         sample();
      end
   endtask

   task automatic load(input logic [47:0] d, input int n, input int h1, input int h0);
      logic [47:0] dd;
      dd = d;
      hq.delete();
      for (int i = 0; i < n; i++) hq.push_back(dd[47-i] ? h1 : h0);
   endtask

   // Drive the pulses in hq, then 'tail' low cycles after the final fall.
   task automatic play(input int tail);
      for (int i = 0; i < hq.size(); i++) begin
         drive(1'b1, hq[i]);
         if (i == 23) window = 1'b1;
         if (i != hq.size() - 1) drive(1'b0, PER - hq[i]);
      end
      tail_start = stepn;
      drive(1'b0, tail);
      window = 1'b0;
   endtask

   function automatic logic [23:0] model_pixel();
      logic [23:0] r = '0;
      for (int i = 0; i < 24; i++) r = {r[22:0], (hq[i] >= THR)};
      return r;
   endfunction

   function automatic int model_fwd_high();
      int s = 0;
      for (int i = 24; i < hq.size(); i++) s += hq[i];
      return s * FWD;
   endfunction

   initial begin
      int nb;
      int e_valid, e_err, e_dhi;
      logic [23:0] e_rgb;

      window = 1'b0;
      led_if.din = 1'b0;
      clear_mon();
      model_rgb = '0;

      vt[0] = '{48'hA50FC3_000000, 24, 60, 20, 24'hA50FC3, 1, 0, 0};
      vt[1] = '{48'hFFFFFF_000000, 24, 39, 20, 24'h000000, 1, 0, 0};
      vt[2] = '{48'hFFFFFF_000000, 24, 40, 20, 24'hFFFFFF, 1, 0, 0};
      vt[3] = '{48'h123456_ABCDEF, 48, 60, 20, 24'h123456, 1, 0, 1160};
      vt[4] = '{48'hB6D000_000000, 10, 60, 20, 24'h123456, 0, 1, 0};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb_out",   led_if.rgb_out,   0);
      check("rst_rgb_valid", led_if.rgb_valid, 0);
      check("rst_dout",      led_if.dout,      0);
      check("rst_busy",      led_if.busy,      0);
      check("rst_err",       led_if.err,       0);
      rst = 1'b0;
      drive(1'b0, RC);

      // Table-driven frames
      for (int i = 0; i < 5; i++) begin
         clear_mon();
         load(vt[i].data, vt[i].nbits, vt[i].h1, vt[i].h0);
         play(RC);
         check($sformatf("tbl%0d_valid_cnt", i), n_valid, vt[i].exp_valid);
         check($sformatf("tbl%0d_err_cnt", i), n_err, vt[i].exp_err);
         check($sformatf("tbl%0d_rgb_out", i), led_if.rgb_out, vt[i].exp_rgb);
         check($sformatf("tbl%0d_evt_step", i), first_evt - tail_start, RC);
         check($sformatf("tbl%0d_dout_high", i), dout_hi, vt[i].exp_dhi * FWD);
         check($sformatf("tbl%0d_dout_trace", i), dout_mis, 0);
         check($sformatf("tbl%0d_busy_end", i), led_if.busy, 0);
         model_rgb = vt[i].exp_rgb;
      end

      // Gap one short, then a rise: no latch until the full gap.
      clear_mon();
      load(48'hA50FC3_000000, 24, 60, 20);
      play(RC - 1);
      check("gap_short_valid", n_valid, 0);
      check("gap_short_busy", led_if.busy, 1);
      window = 1'b1;
      drive(1'b1, 60);
      tail_start = stepn;
      drive(1'b0, RC);
      window = 1'b0;
      check("gap_full_valid", n_valid, 1);
      check("gap_full_rgb", led_if.rgb_out, 24'hA50FC3);
      check("gap_full_step", first_evt - tail_start, RC);
      check("gap_extra_dout", dout_hi, 60 * FWD);
      check("gap_dout_trace", dout_mis, 0);
      model_rgb = 24'hA50FC3;

      // Randomized frames against the pulse-width model
      for (int f = 0; f < 6; f++) begin
         clear_mon();
         nb = ($urandom % 4 == 0) ? int'($urandom_range(23, 1)) : int'($urandom_range(40, 24));
         hq.delete();
         for (int i = 0; i < nb; i++)
            hq.push_back(($urandom % 2) ? int'($urandom_range(90, THR)) : int'($urandom_range(THR - 1, 5)));
         if (nb >= 24) begin
            e_rgb = model_pixel(); e_valid = 1; e_err = 0; e_dhi = model_fwd_high();
            model_rgb = e_rgb;
         end else begin
            e_rgb = model_rgb; e_valid = 0; e_err = 1; e_dhi = 0;
         end
         play(RC);
         check($sformatf("rnd%0d_valid_cnt", f), n_valid, e_valid);
         check($sformatf("rnd%0d_err_cnt", f), n_err, e_err);
         check($sformatf("rnd%0d_rgb_out", f), led_if.rgb_out, e_rgb);
         check($sformatf("rnd%0d_dout_high", f), dout_hi, e_dhi);
         check($sformatf("rnd%0d_dout_trace", f), dout_mis, 0);
      end

      // Stuck-high line
      clear_mon();
      drive(1'b1, 255);
      check("stuck_err_cnt", n_err, 1);
      check("stuck_err_step", first_evt, 255);
      check("stuck_busy", led_if.busy, 0);
      drive(1'b0, RC - 1);
      load(48'h5A5A5A_000000, 24, 60, 20);
      play(RC);
      check("stuck_early_frame_valid", n_valid, 0);
      check("stuck_early_frame_err", n_err, 1);
      check("stuck_rgb_hold", led_if.rgb_out, model_rgb);
      clear_mon();
      play(RC);
      check("stuck_after_valid", n_valid, 1);
      check("stuck_after_rgb", led_if.rgb_out, 24'h5A5A5A);

      // Reset in the middle of a frame
      clear_mon();
      load(48'hC3C3C3_000000, 24, 60, 20);
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, hq[i]);
         drive(1'b0, PER - hq[i]);
      end
      check("midrst_busy_before", led_if.busy, 1);
      rst = 1'b1;
      #1;
      check("midrst_rgb_out", led_if.rgb_out, 0);
      check("midrst_busy", led_if.busy, 0);
      check("midrst_valid", led_if.rgb_valid, 0);
      check("midrst_dout", led_if.dout, 0);
      check("midrst_err", led_if.err, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_mon();
      drive(1'b0, RC);
      play(RC);
      check("midrst_after_valid", n_valid, 1);
      check("midrst_after_err", n_err, 0);
      check("midrst_after_rgb", led_if.rgb_out, 24'hC3C3C3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/smart_led_bit_decoder.md
# smart_led_bit_decoder

Decodes the single-wire, pulse-width-encoded smart-LED bitstream delivered by the input selector into one 24-bit pixel word per frame, and forwards all bits after the first 24 to the next LED in the chain. Sits directly downstream of the input selector's output and upstream of the PWM/colour stage, which consumes `rgb_out` on `rgb_valid`.

## Interface
- `THRESHOLD`, 40: high width in clk cycles at or above which a bit decodes as 1.
- `RESET_CYCLES`, 2500: low time in clk cycles that marks frame end (latch).
- `MAX_HIGH`, 255: high width in clk cycles that flags a stuck-high line.
- `CNT_W`, 12: width of the pulse counter; must hold `RESET_CYCLES`.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `din` input 1: serial data from the input selector, synchronous to `clk`.
- `rgb_out` output 24: last latched pixel, MSB first as received (G[23:16], R[15:8], B[7:0]).
- `rgb_valid` output 1: one-cycle pulse when `rgb_out` updates.
- `dout` output 1: forwarded stream to the next LED.
- `busy` output 1: high while a frame is in progress (not SYNC or IDLE).
- `err` output 1: one-cycle pulse on a stuck-high or partial-frame event.

## Operation
- `din_q` registers `din`; rise = `din & ~din_q`; fall = `~din & din_q`.
- The pulse counter loads 1 on any edge and otherwise increments, saturating at 2^CNT_W−1. At a fall, the counter holds H, the number of cycles `din` was sampled high.
- `bitcnt` runs 0..24; the shift register `shreg` is 24 bits, shifted MSB-first.
- States:
  - SYNC: entered from reset and after any error. Waits for `din_q` low for `RESET_CYCLES` consecutive cycles, then goes to IDLE. A rise restarts the wait.
  - IDLE: on a rise, go to HIGH.
  - HIGH:
    - On a fall, shift in bit = (H ≥ THRESHOLD) and increment `bitcnt`. If `bitcnt` becomes 24, go to FORWARD; otherwise go to LOW.
    - If the counter reaches `MAX_HIGH` while high, pulse `err`, clear `bitcnt`, and go to SYNC.
  - LOW:
    - On a rise, go to HIGH.
    - If the low count reaches `RESET_CYCLES` with 0 < `bitcnt` < 24, the frame is partial: pulse `err`, discard `shreg`, clear `bitcnt`, and go to IDLE. `rgb_out` is unchanged.
  - FORWARD:
    - `dout` = `din_q`.
    - When the low count reaches `RESET_CYCLES`: `rgb_out` ← `shreg`, pulse `rgb_valid`, clear `bitcnt`, go to IDLE.
    - Rises inside FORWARD do not affect `shreg`.
- `dout` is 0 in every state other than FORWARD.
- Boundary conditions:
  - H = THRESHOLD−1 decodes as 0; H = THRESHOLD decodes as 1.
  - A low count exactly equal to `RESET_CYCLES` is a latch; one cycle less is not.
  - If a rise and the `RESET_CYCLES` terminal count coincide, the rise wins (no latch).
- Reset asserted mid-frame: all state clears immediately, `rgb_out` returns to 0, and the block re-enters SYNC.

## Timing
- Reset values: `rgb_out`=0, `rgb_valid`=0, `dout`=0, `busy`=0, `err`=0, state=SYNC.
- Decode latency: the bit is shifted in on the cycle the fall is detected, which is 1 cycle after `din` falls.
- `rgb_valid` asserts 1 cycle after the `RESET_CYCLES`-th low sample. `rgb_out` is stable from that cycle until the next latch.
- `dout` lags `din` by exactly 1 cycle.
- All outputs are registered. The block has no combinational path from `din`.

## Configuration
- `SMART_LED_FORWARD_EN` defined: FORWARD drives `dout` = `din_q` as above.
- `SMART_LED_FORWARD_EN` undefined: `dout` is tied to 0. FORWARD still ignores extra bits and still latches on the reset gap, so decode behaviour is identical.

## Structure
- Package `smart_led_pkg`:
  - state enum (SYNC, IDLE, HIGH, LOW, FORWARD)
  - `PIXEL_W`=24
  - default `THRESHOLD`, `RESET_CYCLES`, `MAX_HIGH`, `CNT_W`
- Sub-module `smart_led_pulse_timer`: owns the `din_q` edge detector and the saturating counter, and exports rise, fall and count to the FSM in `smart_led_bit_decoder`.

## Test plan
All scenarios use `THRESHOLD`=40, `RESET_CYCLES`=300, and a 100-cycle bit period.
- Frame 0xA50FC3 (1 = 60 high, 0 = 20 high), then 300 low -> one `rgb_valid` pulse with `rgb_out`=0xA50FC3, `err`=0, `dout` stays 0.
- Threshold edge: 24 bits, all with H=39 -> `rgb_out`=0x000000. Repeat with H=40 -> `rgb_out`=0xFFFFFF.
- Forwarding: 48 bits (0x123456 then 0xABCDEF), then 300 low -> `rgb_out`=0x123456 and `dout` replays the second 24 pulses delayed 1 cycle. With the macro undefined, `dout` stays 0.
- Partial frame: 10 bits, then 300 low -> `err` pulses once, no `rgb_valid`, `rgb_out` keeps its prior value.
- Stuck high: `din` held high for 255 cycles -> `err` pulse and state SYNC. A valid frame is only accepted after 300 low cycles.
- Reset mid-frame: assert `rst` after 12 bits -> all outputs return to 0 within the same cycle. After 300 low cycles, a full frame decodes correctly.
